// File: rtl/pifo_task_dispatch.sv
// pifo_task_dispatch
// Ingress task buffer and dispatcher for the multi-tree PIFO SRAM array.
// Each ingress channel owns a task FIFO. Each FIFO head is routed to its root
// RPU (tree_id mod NUM_RPU). Every RPU has its own round-robin arbiter across
// channels, and its own ready backpressure. Tasks are registered into
// per-RPU dispatch registers.
//
// Ports:
//   i_clk, i_arst_n            clock, asynchronous active-low reset
//   i_push/i_pop/i_tree_id/
//   i_push_data                per-channel task requests (op = {pop,push})
//   o_full/o_empty             per-channel FIFO status (registered counts)
//   i_rpu_ready                per-RPU ready
//   o_rpu_push/o_rpu_pop/
//   o_rpu_tree_id/
//   o_rpu_push_data            registered per-RPU dispatch outputs
//   o_drop_cnt                 per-channel count of writes dropped because
//                              the FIFO was full
//
// Optional feature: define PIFO_TASK_DISPATCH_STATS_EN to build the
// saturating per-channel drop counters. Otherwise o_drop_cnt is tied to 0.
module pifo_task_dispatch #(
  parameter int PTW           = 16,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int NUM_CH        = 4,
  parameter int NUM_RPU       = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int DROP_CNT_W    = 8
) (
  input  logic                                    i_clk,
  input  logic                                    i_arst_n,
  input  logic [NUM_CH-1:0]                       i_push,
  input  logic [NUM_CH-1:0]                       i_pop,
  input  logic [NUM_CH-1:0][TREE_NUM_BITS-1:0]    i_tree_id,
  input  logic [NUM_CH-1:0][PTW-1:0]              i_push_data,
  output logic [NUM_CH-1:0]                       o_full,
  output logic [NUM_CH-1:0]                       o_empty,
  input  logic [NUM_RPU-1:0]                      i_rpu_ready,
  output logic [NUM_RPU-1:0]                      o_rpu_push,
  output logic [NUM_RPU-1:0]                      o_rpu_pop,
  output logic [NUM_RPU-1:0][TREE_NUM_BITS-1:0]   o_rpu_tree_id,
  output logic [NUM_RPU-1:0][PTW-1:0]             o_rpu_push_data,
  output logic [NUM_CH-1:0][DROP_CNT_W-1:0]       o_drop_cnt
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TB  = TREE_NUM_BITS;
  localparam int EW  = 2 + TB + PTW;

  logic [EW-1:0]                 mem_q [NUM_CH][FIFO_DEPTH];
  logic [NUM_CH-1:0][AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [NUM_CH-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0]             wr_en, rd_en, full, empty;
  logic [NUM_CH-1:0][EW-1:0]     wr_entry, head;
  logic [NUM_RPU-1:0][CHW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_RPU-1:0]            grant_vld;
  logic [NUM_RPU-1:0][CHW-1:0]   grant_ch;
  logic [NUM_RPU-1:0]            rpu_push_q, rpu_push_d, rpu_pop_q, rpu_pop_d;
  logic [NUM_RPU-1:0][TB-1:0]    rpu_tree_q, rpu_tree_d;
  logic [NUM_RPU-1:0][PTW-1:0]   rpu_data_q, rpu_data_d;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]  = (cnt_q[c] == CW'(FIFO_DEPTH));
      empty[c] = (cnt_q[c] == '0);
    end
  end

  assign o_full  = full;
  assign o_empty = empty;

  // FIFO write side and pointer/count update. A write into a full FIFO is
  // dropped even when the head leaves in the same cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_en[c]    = (i_push[c] | i_pop[c]) & ~full[c];
      wr_entry[c] = {i_pop[c], i_push[c], i_tree_id[c],
                     (i_push[c] ? i_push_data[c] : {PTW{1'b0}})};
      head[c]     = mem_q[c][rptr_q[c]];
      wptr_d[c]   = wptr_q[c] + AW'(wr_en[c]);
      rptr_d[c]   = rptr_q[c] + AW'(rd_en[c]);
      cnt_d[c]    = cnt_q[c] + CW'(wr_en[c]) - CW'(rd_en[c]);
    end
  end

  // Per-RPU round-robin arbitration. The search starts at rr_ptr and wraps
  // over NUM_CH. A head targets exactly one RPU, so rd_en has at most one
  // setter per channel.
  always_comb begin
    int idx;
    logic [CHW-1:0] sel;
    rd_en     = '0;
    grant_vld = '0;
    grant_ch  = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int r = 0; r < NUM_RPU; r++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (int'(rr_ptr_q[r]) + k) % NUM_CH;
        sel = CHW'(idx);
        if (i_rpu_ready[r] && !grant_vld[r] && !empty[sel] &&
            ((head[sel][PTW +: TB] & TB'(NUM_RPU - 1)) == TB'(r))) begin
          grant_vld[r] = 1'b1;
          grant_ch[r]  = sel;
        end
      end
      if (grant_vld[r]) begin
        rd_en[grant_ch[r]] = 1'b1;
        rr_ptr_d[r]        = CHW'((int'(grant_ch[r]) + 1) % NUM_CH);
      end
    end
  end

  always_comb begin
    rpu_push_d = '0;
    rpu_pop_d  = '0;
    rpu_tree_d = rpu_tree_q;
    rpu_data_d = rpu_data_q;
    for (int r = 0; r < NUM_RPU; r++) begin
      if (grant_vld[r]) begin
        rpu_push_d[r] = head[grant_ch[r]][PTW + TB];
        rpu_pop_d[r]  = head[grant_ch[r]][PTW + TB + 1];
        rpu_tree_d[r] = head[grant_ch[r]][PTW +: TB];
        rpu_data_d[r] = head[grant_ch[r]][PTW-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      rpu_push_q <= '0;
      rpu_pop_q  <= '0;
      rpu_tree_q <= '0;
      rpu_data_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      rpu_push_q <= rpu_push_d;
      rpu_pop_q  <= rpu_pop_d;
      rpu_tree_q <= rpu_tree_d;
      rpu_data_q <= rpu_data_d;
    end
  end

  // Storage carries no reset; validity is tracked by the counts.
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) mem_q[c][wptr_q[c]] <= wr_entry[c];
    end
  end

  assign o_rpu_push      = rpu_push_q;
  assign o_rpu_pop       = rpu_pop_q;
  assign o_rpu_tree_id   = rpu_tree_q;
  assign o_rpu_push_data = rpu_data_q;

`ifdef PIFO_TASK_DISPATCH_STATS_EN
  logic [NUM_CH-1:0][DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of writes dropped because the FIFO was full.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((i_push[c] | i_pop[c]) && full[c] && !(&drop_cnt_q[c]))
        drop_cnt_d[c] = drop_cnt_q[c] + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) drop_cnt_q <= '0;
    else           drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = '0;
`endif

endmodule
